dispense_seq: RTL and testbench

- Parametrised dispense sequencer. Generalises the fixed three-motor R/Y/B loader to N_CH channels.
- Adds a per-request channel mask (empty channels are skipped), a per-channel watchdog timeout, abort, a fault state with operator acknowledge, and status outputs.
- Sits between the colour-reading front end (rgb_full), the operator keypad (enter, abort) and the motor drivers and their end-of-dose flags.

---
 rtl/dispense_seq.sv | 129 ++++++++++++
 tb/tb_dispense_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dispense_seq.sv
// Dispense sequencer: serves the masked channels from highest to lowest, one motor at a time.
// Each channel has a watchdog. Abort, a latched fault state and status outputs are included.
module dispense_seq #(
    parameter int N_CH    = 3,
    parameter int TMO_W   = 16,
    parameter int TIMEOUT = 50000,
    parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rgb_full,
    input  logic            enter,
    input  logic            abort,
    input  logic [N_CH-1:0] ch_mask,
    input  logic [N_CH-1:0] flags,
    output logic [N_CH-1:0] motores,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [CH_W-1:0] cur_ch,
    output logic [CH_W-1:0] err_ch
);

    if (TIMEOUT < 0 || longint'(TIMEOUT) >= (longint'(1) << TMO_W)) begin : g_tmo_chk
        $error("dispense_seq: TIMEOUT does not fit in TMO_W bits");
    end

    typedef enum logic [2:0] {
        LECTURA = 3'd0,
        ESPERA  = 3'd1,
        CARGA   = 3'd2,
        FIN     = 3'd3,
        FAULT   = 3'd4
    } state_t;

    state_t            state, state_nx;
    logic [N_CH-1:0]   mask, mask_nx, rest;
    logic [CH_W-1:0]   cur_nx, err_nx;
    logic [TMO_W-1:0]  timer, timer_nx;
    logic              enter_q, enter_rise;

    assign enter_rise = enter & ~enter_q;

    function automatic logic [CH_W-1:0] top_bit(input logic [N_CH-1:0] m);
        top_bit = '0;
        for (int i = 0; i < N_CH; i++)
            if (m[i]) top_bit = CH_W'(i);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= LECTURA;
            mask    <= '0;
            cur_ch  <= '0;
            err_ch  <= '0;
            timer   <= '0;
            enter_q <= 1'b0;
        end else begin
            state   <= state_nx;
            mask    <= mask_nx;
            cur_ch  <= cur_nx;
            err_ch  <= err_nx;
            timer   <= timer_nx;
            enter_q <= enter;
        end
    end

    // Outputs decode from the registered state only, so an async reset drops them at once.
    always_comb begin
        state_nx = state;
        mask_nx  = mask;
        cur_nx   = cur_ch;
        err_nx   = err_ch;
        timer_nx = timer;
        motores  = '0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        rest     = mask & ~(N_CH'(1) << cur_ch);
        case (state)
            LECTURA: if (rgb_full) state_nx = ESPERA;
            ESPERA: begin
                if (!rgb_full) begin
                    state_nx = LECTURA;
                end else if (enter_rise) begin
                    mask_nx = ch_mask;
                    if (ch_mask == '0) begin
                        state_nx = FIN;
                    end else begin
                        state_nx = CARGA;
                        cur_nx   = top_bit(ch_mask);
                        timer_nx = '0;
                    end
                end
            end
            CARGA: begin
                motores = N_CH'(1) << cur_ch;
                busy    = 1'b1;
                if (timer != '1) timer_nx = timer + 1'b1;
                if (abort) begin
                    state_nx = LECTURA;
                    mask_nx  = '0;
                end else if (flags[cur_ch]) begin
                    // Lower channels are all that remain, so the top set bit is the next one down.
                    mask_nx = rest;
                    if (rest == '0) begin
                        state_nx = FIN;
                    end else begin
                        cur_nx   = top_bit(rest);
                        timer_nx = '0;
                    end
                end else if (TIMEOUT != 0 && timer == TMO_W'(TIMEOUT - 1)) begin
                    state_nx = FAULT;
                    err_nx   = cur_ch;
                end
            end
            FIN: begin
                done     = 1'b1;
                state_nx = LECTURA;
            end
            FAULT: begin
                error = 1'b1;
                if (enter_rise || abort) state_nx = LECTURA;
            end
            default: state_nx = LECTURA;
        endcase
    end

endmodule

// File: tb/tb_dispense_seq.sv
// Bench for dispense_seq: queue-based job model checked every cycle, plus directed literal checks.
module tb_dispense_seq;
    localparam int N   = 3;
    localparam int TMO = 8;

    logic         clk = 1'b0;
    logic         reset, rgb_full, enter, abort;
    logic [N-1:0] ch_mask, flags, motores;
    logic         busy, done, error;
    logic [1:0]   cur_ch, err_ch;

    int n_cmp = 0;
    int n_err = 0;

    dispense_seq #(.N_CH(N), .TMO_W(16), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .rgb_full(rgb_full), .enter(enter), .abort(abort),
        .ch_mask(ch_mask), .flags(flags), .motores(motores), .busy(busy), .done(done),
        .error(error), .cur_ch(cur_ch), .err_ch(err_ch)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Job model: phase 0 idle, 1 colour ready, 2 dispensing, 3 finished, 4 faulted.
    int m_ph, m_cur, m_err, m_age;
    int pend[$];
    bit m_eprev, m_rise;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ph = 0; m_cur = 0; m_err = 0; m_age = 0; m_eprev = 0;
            pend.delete();
        end else begin
            m_rise  = enter && !m_eprev;
            m_eprev = enter;
            case (m_ph)
                0: if (rgb_full) m_ph = 1;
                1: if (!rgb_full) m_ph = 0;
                   else if (m_rise) begin
                       pend.delete();
                       for (int c = N - 1; c >= 0; c--) if (ch_mask[c]) pend.push_back(c);
                       if (pend.size() == 0) m_ph = 3;
                       else begin m_cur = pend[0]; m_age = 0; m_ph = 2; end
                   end
                2: begin
                    m_age++;
                    if (abort) begin m_ph = 0; pend.delete(); end
                    else if (flags[m_cur]) begin
                        void'(pend.pop_front());
                        if (pend.size() == 0) m_ph = 3;
                        else begin m_cur = pend[0]; m_age = 0; end
                    end else if (TMO != 0 && m_age == TMO) begin
                        m_ph = 4; m_err = m_cur;
                    end
                end
                3: m_ph = 0;
                4: if (m_rise || abort) m_ph = 0;
                default: m_ph = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("motores", int'(motores), (m_ph == 2) ? (1 << m_cur) : 0);
        check("busy", int'(busy), int'(m_ph == 2));
        check("done", int'(done), int'(m_ph == 3));
        check("error", int'(error), int'(m_ph == 4));
        check("cur_ch", int'(cur_ch), m_cur);
        if (m_ph == 4) check("err_ch", int'(err_ch), m_err);
    end

    // Observation log of the DUT for the directed literal checks.
    logic [N-1:0] seq[$];
    logic [N-1:0] prev_mot = '0;
    int on_cnt[N];
    int done_cnt = 0;

    always @(negedge clk) begin
        if (motores != '0 && motores != prev_mot) seq.push_back(motores);
        prev_mot = motores;
        for (int c = 0; c < N; c++) if (motores == N'(1 << c)) on_cnt[c]++;
        if (done) done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_motor(input int ch);
        int k = 0;
        while (motores != N'(1 << ch) && k < 20) begin tick(1); k++; end
        if (k == 20) begin
            n_cmp++; n_err++;
            $display("FAIL wait_motor: channel %0d never driven, motores=%b", ch, motores);
        end
    endtask

    task automatic dose(input int ch);
        wait_motor(ch);
        tick(3);
        flags[ch] = 1'b1;
        tick(1);
        flags[ch] = 1'b0;
    endtask

    task automatic start_job(input logic [N-1:0] m, input bit keep);
        tick(2);
        ch_mask = m;
        enter   = 1'b1;
        tick(1);
        if (!keep) enter = 1'b0;
    endtask

    int s0, d0, o0[N];

    task automatic snap();
        s0 = seq.size(); d0 = done_cnt;
        for (int c = 0; c < N; c++) o0[c] = on_cnt[c];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int c = 0; c < N; c++) on_cnt[c] = 0;
        reset = 1'b0; rgb_full = 1'b0; enter = 1'b0; abort = 1'b0;
        ch_mask = '0; flags = '0;
        tick(3); #1;
        check("rst_motores", int'(motores), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_error", int'(error), 0);
        check("rst_cur_ch", int'(cur_ch), 0);
        tick(1);
        reset = 1'b1;
        rgb_full = 1'b1;

        // Full mask, each flag three cycles after its motor.
        snap();
        start_job(3'b111, 0);
        dose(2); dose(1); dose(0);
        tick(3); #1;
        check("t1_seq_len", seq.size() - s0, 3);
        check("t1_seq0", int'(seq[s0]), 4);
        check("t1_seq1", int'(seq[s0 + 1]), 2);
        check("t1_seq2", int'(seq[s0 + 2]), 1);
        check("t1_done", done_cnt - d0, 1);
        check("t1_ch2_cycles", on_cnt[2] - o0[2], 4);

        // Sparse mask with a spurious flag on the skipped channel.
        snap();
        start_job(3'b101, 0);
        wait_motor(2);
        flags = 3'b010; tick(1); flags = '0;
        tick(2);
        flags = 3'b100; tick(1); flags = '0;
        dose(0);
        tick(3); #1;
        check("t2_seq_len", seq.size() - s0, 2);
        check("t2_seq0", int'(seq[s0]), 4);
        check("t2_seq1", int'(seq[s0 + 1]), 1);
        check("t2_ch1_cycles", on_cnt[1] - o0[1], 0);
        check("t2_done", done_cnt - d0, 1);

        // Watchdog on channel 1, cleared by an enter pulse.
        snap();
        start_job(3'b010, 0);
        tick(12); #1;
        check("t3_error", int'(error), 1);
        check("t3_err_ch", int'(err_ch), 1);
        check("t3_motores", int'(motores), 0);
        check("t3_ch1_cycles", on_cnt[1] - o0[1], 8);
        enter = 1'b1; tick(1); enter = 1'b0; #1;
        check("t3_cleared", int'(error), 0);

        // Abort on channel 1 in the same cycle as its flag.
        snap();
        start_job(3'b111, 0);
        dose(2);
        wait_motor(1);
        tick(1);
        abort = 1'b1; flags = 3'b010;
        tick(1);
        abort = 1'b0; flags = '0; #1;
        check("t4_motores", int'(motores), 0);
        tick(4); #1;
        check("t4_done", done_cnt - d0, 0);
        check("t4_seq_len", seq.size() - s0, 2);
        check("t4_ch0_cycles", on_cnt[0] - o0[0], 0);

        // Enter held high through a fault: one start, no auto-clear.
        snap();
        start_job(3'b001, 1);
        tick(12); #1;
        check("t5_error", int'(error), 1);
        tick(4); #1;
        check("t5_held", int'(error), 1);
        abort = 1'b1; tick(1); abort = 1'b0; #1;
        check("t5_abort_clr", int'(error), 0);
        tick(4); #1;
        check("t5_ch0_cycles", on_cnt[0] - o0[0], 8);
        check("t5_seq_len", seq.size() - s0, 1);
        enter = 1'b0;

        // Empty mask: done with no motor.
        snap();
        start_job(3'b000, 0);
        tick(3); #1;
        check("t5b_done", done_cnt - d0, 1);
        check("t5b_seq_len", seq.size() - s0, 0);

        // Reset mid-dispense, then rgb_full drop racing enter.
        snap();
        start_job(3'b111, 0);
        wait_motor(2);
        @(posedge clk); #2;
        reset = 1'b0; #1;
        check("t6_async_mot", int'(motores), 0);
        check("t6_async_busy", int'(busy), 0);
        tick(2);
        reset = 1'b1;
        tick(2);
        rgb_full = 1'b0; enter = 1'b1; ch_mask = 3'b111;
        tick(1);
        enter = 1'b0;
        tick(4); #1;
        check("t6_done", done_cnt - d0, 0);
        check("t6_seq_len", seq.size() - s0, 1);
        check("t6_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
